// File: rtl/round_key_store.sv
// ---------------------------------------------------------------------------
// round_key_store
//
// Purpose:
//   Captures the round keys produced by the key schedule into a small register
//   file. It then replays them to the cipher round core on a request/valid
//   handshake, so that one key expansion can serve many blocks.
//   Encryption replays keys 0..NUM_KEYS-1. Decryption replays them in reverse
//   order.
//
// Ports:
//   clk       in   system clock; all registers update on the rising edge
//   reset     in   synchronous, active-high reset
//   wr_en     in   write strobe from the key schedule
//   wr_index  in   index of the key being written
//   wr_key    in   round-key data
//   encrypt   in   direction latched when a start is accepted (1=enc, 0=dec)
//   start     in   begin a replay sequence (needs all keys loaded)
//   rd_req    in   request the next round key (data appears one cycle later)
//   rd_valid  out  rd_key/rd_index valid this cycle
//   rd_key    out  served round key (holds its value between requests)
//   rd_index  out  index of the served key
//   loaded    out  every key slot has been written since reset
//   busy      out  a replay sequence is in progress
//   done      out  one-cycle pulse after the last key of a sequence
//   err       out  sticky protocol-error flag, cleared only by reset
// ---------------------------------------------------------------------------
module round_key_store #(
  parameter int KEY_W    = 128,
  parameter int NUM_KEYS = 13,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             encrypt,
  input  logic             start,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic [IDX_W-1:0] rd_index,
  output logic             loaded,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Key storage and bookkeeping
  logic [KEY_W-1:0]    mem [NUM_KEYS];
  logic [NUM_KEYS-1:0] mask;
  logic                dir;
  logic [IDX_W-1:0]    ptr;
  logic                err_q;

  // Output register stage
  logic                vld_p1;
  logic [KEY_W-1:0]    rd_key_p1;
  logic [IDX_W-1:0]    rd_index_p1;

  // Per-cycle decisions from the next-state logic
  logic wr_window;
  logic wr_in_range;
  logic wr_commit;
  logic wr_bad;
  logic start_ok;
  logic start_bad;
  logic serve_fire;
  logic serve_last;

  // Pointer helpers
  function automatic logic [IDX_W-1:0] first_ptr(input logic enc);
    return enc ? FIRST_IDX : LAST_IDX;
  endfunction

  function automatic logic [IDX_W-1:0] step_ptr(input logic [IDX_W-1:0] p,
                                                input logic             d);
    return d ? p + IDX_W'(1) : p - IDX_W'(1);
  endfunction

  function automatic logic is_final(input logic [IDX_W-1:0] p,
                                    input logic             d);
    return d ? (p == LAST_IDX) : (p == FIRST_IDX);
  endfunction

  // Status decodes
  assign loaded = &mask;
  assign busy   = (state == S_SERVE);
  assign done   = (state == S_DONE);
  assign err    = err_q;

  assign rd_valid = vld_p1;
  assign rd_key   = rd_key_p1;
  assign rd_index = rd_index_p1;

  // Next-state and per-cycle control decisions
  always_comb begin
    state_nxt   = state;
    wr_window   = 1'b0;
    wr_in_range = 1'b0;
    wr_commit   = 1'b0;
    wr_bad      = 1'b0;
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    serve_fire  = 1'b0;
    serve_last  = 1'b0;

    // Key writes are only legal while no replay is running.
    // Anything else is a protocol error, and the storage is left untouched.
    wr_window   = (state == S_IDLE) || (state == S_DONE);
    wr_in_range = (wr_index <= LAST_IDX);
    wr_commit   = wr_en && wr_window && wr_in_range;
    wr_bad      = wr_en && !(wr_window && wr_in_range);

    case (state)
      S_IDLE: begin
        // start sees loaded as registered, so a final key written in the same
        // cycle as start does not count yet.
        if (start) begin
          if (loaded) begin
            start_ok  = 1'b1;
            state_nxt = S_SERVE;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_SERVE: begin
        if (rd_req) begin
          serve_fire = 1'b1;
          serve_last = is_final(ptr, dir);
          if (serve_last) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control registers, pointer and output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      mask        <= '0;
      err_q       <= 1'b0;
      dir         <= 1'b1;
      ptr         <= '0;
      vld_p1      <= 1'b0;
      rd_key_p1   <= '0;
      rd_index_p1 <= '0;
    end else begin
      if (wr_commit) begin
        mask[wr_index] <= 1'b1;
      end
      if (wr_bad || start_bad) begin
        err_q <= 1'b1;
      end
      if (start_ok) begin
        dir <= encrypt;
        ptr <= first_ptr(encrypt);
      end

      vld_p1 <= serve_fire;
      if (serve_fire) begin
        rd_key_p1   <= mem[ptr];
        rd_index_p1 <= ptr;
        // The last index ends the sequence; the pointer never wraps.
        if (!serve_last) begin
          ptr <= step_ptr(ptr, dir);
        end
      end
    end
  end

  // Key storage has no reset; the mask alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[wr_index] <= wr_key;
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// ---------------------------------------------------------------------------
// tb_round_key_store
//
// Directed sequence with randomized key data, gap lengths and direction noise.
// The reference model tracks loaded keys, the valid flags and the error flag
// as plain arrays. The expected replay order is built as a queue from the
// direction.
// ---------------------------------------------------------------------------
module tb_round_key_store;

  localparam int KEY_W    = 128;
  localparam int NUM_KEYS = 13;
  localparam int IDX_W    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_index = '0;
  logic [KEY_W-1:0] wr_key = '0;
  logic             encrypt = 1'b0;
  logic             start = 1'b0;
  logic             rd_req = 1'b0;
  logic             rd_valid;
  logic [KEY_W-1:0] rd_key;
  logic [IDX_W-1:0] rd_index;
  logic             loaded;
  logic             busy;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [KEY_W-1:0] ref_mem  [NUM_KEYS];
  bit               ref_mask [NUM_KEYS];
  bit               ref_err;

  always #5 clk = ~clk;

  round_key_store #(
    .KEY_W(KEY_W),
    .NUM_KEYS(NUM_KEYS),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_index(wr_index),
    .wr_key(wr_key),
    .encrypt(encrypt),
    .start(start),
    .rd_req(rd_req),
    .rd_valid(rd_valid),
    .rd_key(rd_key),
    .rd_index(rd_index),
    .loaded(loaded),
    .busy(busy),
    .done(done),
    .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [KEY_W-1:0] obs,
                      input logic [KEY_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_loaded();
    bit all_set = 1'b1;
    for (int i = 0; i < NUM_KEYS; i++) all_set = all_set & ref_mask[i];
    return all_set;
  endfunction

  function automatic logic [KEY_W-1:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) ref_mask[i] = 1'b0;
    ref_err = 1'b0;
    chkb("rst_vld", rd_valid, 1'b0);
    chkw("rst_key", rd_key, '0);
    chkw("rst_idx", KEY_W'(rd_index), '0);
    chkb("rst_loaded", loaded, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_err", err, 1'b0);
  endtask

  task automatic write_key(input int idx, input logic [KEY_W-1:0] key);
    wr_en    = 1'b1;
    wr_index = IDX_W'(idx);
    wr_key   = key;
    step();
    wr_en = 1'b0;
    if (idx < NUM_KEYS) begin
      ref_mem[idx]  = key;
      ref_mask[idx] = 1'b1;
    end else begin
      ref_err = 1'b1;
    end
    chkb("wr_err", err, ref_err);
    chkb("wr_loaded", loaded, ref_loaded());
  endtask

  task automatic load_all(input bit pattern);
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pattern) write_key(i, {32{4'(i)}});
      else         write_key(i, rnd_key());
    end
  endtask

  // gap_mode: 0 = back-to-back, 1 = one idle cycle, 2 = random 0..2 cycles.
  // inject_k: request number on which a write is attempted (-1 = none).
  task automatic run_seq(input bit enc, input int gap_mode, input int inject_k,
                         input bit start_dup);
    int               order[$];
    int               ngap;
    logic [KEY_W-1:0] held_key;
    logic [IDX_W-1:0] held_idx;
    held_key = '0;
    held_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) order.push_back(enc ? k : NUM_KEYS - 1 - k);

    encrypt = enc;
    start   = 1'b1;
    step();
    start   = 1'b0;
    encrypt = 1'($urandom);
    chkb("start_busy", busy, 1'b1);
    chkb("start_vld", rd_valid, 1'b0);
    chkb("start_err", err, ref_err);

    for (int k = 0; k < NUM_KEYS; k++) begin
      rd_req = 1'b1;
      if (k == inject_k) begin
        wr_en    = 1'b1;
        wr_index = 4'd3;
        wr_key   = ~ref_mem[3];
        ref_err  = 1'b1;
      end
      step();
      rd_req = 1'b0;
      wr_en  = 1'b0;
      held_idx = IDX_W'(order[k]);
      held_key = ref_mem[order[k]];
      chkb("srv_vld", rd_valid, 1'b1);
      chkw("srv_idx", KEY_W'(rd_index), KEY_W'(held_idx));
      chkw("srv_key", rd_key, held_key);
      chkb("srv_done", done, k == NUM_KEYS - 1);
      chkb("srv_busy", busy, k != NUM_KEYS - 1);
      chkb("srv_err", err, ref_err);
      if (k < NUM_KEYS - 1) begin
        if (gap_mode == 0)               ngap = 0;
        else if (gap_mode == 1)          ngap = 1;
        else if (k == 0)                 ngap = 1;
        else                             ngap = int'($urandom_range(0, 2));
        for (int g = 0; g < ngap; g++) begin
          start = start_dup && (g == 0);
          step();
          start = 1'b0;
          chkb("gap_vld", rd_valid, 1'b0);
          chkw("gap_key", rd_key, held_key);
          chkw("gap_idx", KEY_W'(rd_index), KEY_W'(held_idx));
          chkb("gap_busy", busy, 1'b1);
          chkb("gap_err", err, ref_err);
        end
      end
    end

    // Cycle in DONE: a start here must be ignored.
    start = start_dup;
    step();
    start = 1'b0;
    chkb("end_done", done, 1'b0);
    chkb("end_vld", rd_valid, 1'b0);
    chkb("end_busy", busy, 1'b0);
    chkw("end_key", rd_key, held_key);
    chkb("end_err", err, ref_err);
  endtask

  initial begin
    logic [KEY_W-1:0] k12;

    // Reset state, then rd_req in IDLE must be ignored
    do_reset();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chkb("idle_rdreq_vld", rd_valid, 1'b0);

    // Patterned load, encrypt back-to-back, decrypt with one-cycle gaps
    load_all(1'b1);
    run_seq(1'b1, 0, -1, 1'b0);
    run_seq(1'b0, 1, -1, 1'b0);

    // Random gaps, start during SERVE/DONE, write attempt to index 3 mid-sequence
    run_seq(1'b1, 2, 1, 1'b1);

    // Partial load: start must flag err; out-of-range write keeps err, mask unchanged
    do_reset();
    for (int i = 0; i < NUM_KEYS - 1; i++) write_key(i, rnd_key());
    rd_req  = 1'b1;
    encrypt = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    ref_err = 1'b1;
    chkb("partial_err", err, 1'b1);
    chkb("partial_busy", busy, 1'b0);
    chkb("partial_vld", rd_valid, 1'b0);
    step();
    rd_req = 1'b0;
    chkb("partial_vld2", rd_valid, 1'b0);
    write_key(13, rnd_key());

    // Final key written together with start: write lands, start is rejected
    do_reset();
    for (int i = 0; i < NUM_KEYS - 1; i++) write_key(i, rnd_key());
    k12      = rnd_key();
    wr_en    = 1'b1;
    wr_index = 4'd12;
    wr_key   = k12;
    encrypt  = 1'b1;
    start    = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    ref_mem[12]  = k12;
    ref_mask[12] = 1'b1;
    ref_err      = 1'b1;
    chkb("simul_err", err, 1'b1);
    chkb("simul_busy", busy, 1'b0);
    chkb("simul_loaded", loaded, 1'b1);
    run_seq(1'b0, 2, -1, 1'b1);

    // Overwrite one key, then reset in the middle of an encrypt sequence
    do_reset();
    load_all(1'b0);
    write_key(5, rnd_key());
    encrypt = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rd_req = 1'b1;
      step();
      chkw("pre_rst_idx", KEY_W'(rd_index), KEY_W'(k));
      chkw("pre_rst_key", rd_key, ref_mem[k]);
    end
    do_reset();
    rd_req  = 1'b0;
    encrypt = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    ref_err = 1'b1;
    chkb("post_rst_err", err, 1'b1);
    chkb("post_rst_busy", busy, 1'b0);
    chkb("post_rst_vld", rd_valid, 1'b0);

    // Fresh random keys, both directions
    do_reset();
    load_all(1'b0);
    write_key(5, rnd_key());
    run_seq(1'b0, 2, -1, 1'b0);
    run_seq(1'b1, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/round_key_store.md
Name: round_key_store

Overview:
- Consumer end of the round-key generation path: captures the 13 round keys emitted by the key schedule (index 0..12) into an internal register file.
- Replays them to the round datapath on a request/valid handshake.
- Encryption order is 0→12; decryption order is 12→0.
- Sits between the key schedule and the cipher round core, so one key expansion serves repeated blocks in either direction.

Parameters:
- KEY_W, 128, round-key width in bits
- NUM_KEYS, 13, number of round keys stored (Anubis-128: R=12, keys 0..12)
- IDX_W, 4, key index width

Ports:
- clk  in  1  system clock; all registers update on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe from key schedule
- wr_index  in  IDX_W  index of key being written
- wr_key  in  KEY_W  round key data
- encrypt  in  1  direction, sampled on accepted start (1=encrypt, 0=decrypt)
- start  in  1  begin a replay sequence
- rd_req  in  1  request next round key
- rd_valid  out  1  rd_key/rd_index valid this cycle
- rd_key  out  KEY_W  served round key
- rd_index  out  IDX_W  index of served key
- loaded  out  1  all NUM_KEYS entries written since reset
- busy  out  1  replay sequence in progress
- done  out  1  one-cycle pulse after last key served
- err  out  1  sticky protocol-error flag, cleared only by reset

Behaviour:
- Reset: valid mask=0, loaded=0, busy=0, done=0, rd_valid=0, rd_key=0, rd_index=0, err=0, FSM=IDLE. Key storage contents are don't-care.
- Write path (states IDLE and DONE only):
  - wr_en=1 and wr_index<NUM_KEYS: mem[wr_index]<=wr_key, mask[wr_index]<=1.
  - Rewriting an index overwrites it; this is legal.
  - wr_index>=NUM_KEYS: write ignored, err<=1.
- loaded = AND of mask; combinational from the mask register. It is visible the cycle after the 13th distinct index is written.
- FSM IDLE:
  - start=1 and loaded=1: latch dir<=encrypt; ptr<=0 if encrypt, else NUM_KEYS-1; busy<=1; go SERVE.
  - start=1 and loaded=0: err<=1, stay IDLE.
  - rd_req in IDLE: ignored; rd_valid stays 0.
- FSM SERVE:
  - rd_req=1: on the next rising edge rd_valid<=1, rd_key<=mem[ptr], rd_index<=ptr. Latency from rd_req to data is 1 cycle.
  - On each served key, ptr increments (dir=1) or decrements (dir=0).
  - rd_req=0: rd_valid<=0; rd_key/rd_index hold last value.
  - Back-to-back rd_req is allowed; throughput is one key per cycle.
  - On serving index 12 (encrypt) or 0 (decrypt): busy<=0, done<=1, go DONE. No pointer wrap-around.
  - start during SERVE: ignored, no error.
  - wr_en during SERVE: write ignored, err<=1, mask unchanged.
- FSM DONE:
  - Lasts 1 cycle: done=1, rd_valid deasserts unless it was set that same edge. Then go IDLE.
  - start in DONE: ignored.
- done is high for exactly one cycle per completed sequence.
- Reset asserted mid-SERVE: all outputs return to reset values next edge. mask clears, so keys must be reloaded before the next start.
- Simultaneous wr_en and start in IDLE with the final missing key: the write is performed. start sees the old loaded=0 and flags err.

Test Plan:
- Load keys mem[i]={32{4'(i)}} for i=0..12, wr_en one per cycle → loaded=1 one cycle after the i=12 write; err=0.
- encrypt=1, start, then rd_req held 13 cycles → rd_index 0,1,…,12 on consecutive cycles. rd_key=32'h00000000…, then 32'h11111111…, …, 32'hCCCCCCCC…. done pulses once one cycle after index 12; busy=0.
- encrypt=0, start, rd_req with 1-cycle gaps → rd_index 12,11,…,0. rd_valid=0 on gap cycles with rd_key held. done pulses after index 0.
- Start after reset with only keys 0..11 written → err=1, busy=0, no rd_valid. Write index 13 → err stays 1, mask unchanged.
- Reset asserted after 5 served keys in an encrypt sequence → next cycle busy=0, rd_valid=0, loaded=0, err=0. start then → err=1.
- wr_en with wr_index=3 during SERVE → err=1, and mem[3] still replays its original value later in the same sequence.
